// File: rtl/clahe_hist_pkg.sv
// Shared types and helpers for the CLAHE histogram read-modify-write controller.
// The counter increment saturates rather than wrapping so bright tiles cannot roll a bin over.
package clahe_hist_pkg;

    typedef enum logic {
        S_CLEAR  = 1'b0,
        S_ACTIVE = 1'b1
    } state_e;

    localparam int unsigned         CNT_W   = 16;
    localparam logic [CNT_W-1:0]    CNT_MAX = {CNT_W{1'b1}};

    // Width-generic saturating increment; callers pass their own all-ones ceiling.
    function automatic logic [63:0] sat_inc(input logic [63:0] x, input logic [63:0] max);
        return (x >= max) ? max : x + 64'd1;
    endfunction

endpackage

// File: rtl/clahe_hist_rmw_ctrl.sv
// Read-modify-write sequencer for one pseudo-dual-port histogram RAM: per-pixel bin
// accumulation with write-to-read forwarding, a full-RAM clear sweep, and readout arbitration.
module clahe_hist_rmw_ctrl
    import clahe_hist_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DEPTH      = 256
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear_start,
    output logic                  clear_busy,
    output logic                  clear_done,
    input  logic                  pix_valid,
    input  logic [ADDR_WIDTH-1:0] pix_bin,
    output logic                  pix_ready,
    input  logic                  rd_req,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_gnt,
    output logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  ram_we_a,
    output logic [ADDR_WIDTH-1:0] ram_addr_a,
    output logic [DATA_WIDTH-1:0] ram_din_a,
    output logic [ADDR_WIDTH-1:0] ram_addr_b,
    input  logic [DATA_WIDTH-1:0] ram_dout_b
);

    localparam logic [DATA_WIDTH-1:0] SAT_MAX  = '1;
    localparam logic [ADDR_WIDTH-1:0] LAST_BIN = ADDR_WIDTH'(DEPTH - 1);

    state_e                  state_q;
    logic                    clr_run_q;
    logic [ADDR_WIDTH-1:0]   clr_cnt_q;
    logic                    clear_done_q;
    logic                    s1_valid_q;
    logic [ADDR_WIDTH-1:0]   s1_bin_q;
    logic                    fwd_valid_q;
    logic [ADDR_WIDTH-1:0]   fwd_addr_q;
    logic [DATA_WIDTH-1:0]   fwd_data_q;
    logic                    rdp_valid_q;
    logic                    rdp_hit_q;
    logic [DATA_WIDTH-1:0]   rdp_data_q;
    logic [DATA_WIDTH-1:0]   rd_hold_q;
    logic [ADDR_WIDTH-1:0]   addr_b_q;

    logic                    active;
    logic                    clearing;
    logic                    pix_acc;
    logic                    fwd_hit;
    logic [DATA_WIDTH-1:0]   s1_old;
    logic [DATA_WIDTH-1:0]   s1_din;
    logic [DATA_WIDTH-1:0]   rd_now;

    // clr_run_q holds the sweep off while reset is applied so every output reads 0.
    assign active   = (state_q == S_ACTIVE);
    assign clearing = (state_q == S_CLEAR) && clr_run_q;

    assign pix_ready = active && !clear_start;
    assign pix_acc   = pix_valid && pix_ready;
    assign rd_gnt    = active && rd_req && !pix_valid && !clear_start;

    assign fwd_hit = fwd_valid_q && (fwd_addr_q == s1_bin_q);
    assign s1_old  = fwd_hit ? fwd_data_q : ram_dout_b;
    assign s1_din  = DATA_WIDTH'(sat_inc(64'(s1_old), 64'(SAT_MAX)));

    assign ram_we_a   = clearing || s1_valid_q;
    assign ram_addr_a = clearing ? clr_cnt_q : s1_bin_q;
    assign ram_din_a  = s1_valid_q ? s1_din : '0;
    assign ram_addr_b = pix_acc ? pix_bin : (rd_gnt ? rd_addr : addr_b_q);

    assign clear_busy = clearing;
    assign clear_done = clear_done_q;
    assign rd_valid   = rdp_valid_q;
    assign rd_now     = rdp_hit_q ? rdp_data_q : ram_dout_b;
    assign rd_data    = rdp_valid_q ? rd_now : rd_hold_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_CLEAR;
            clr_run_q    <= 1'b0;
            clr_cnt_q    <= '0;
            clear_done_q <= 1'b0;
            s1_valid_q   <= 1'b0;
            s1_bin_q     <= '0;
            fwd_valid_q  <= 1'b0;
            fwd_addr_q   <= '0;
            fwd_data_q   <= '0;
            rdp_valid_q  <= 1'b0;
            rdp_hit_q    <= 1'b0;
            rdp_data_q   <= '0;
            rd_hold_q    <= '0;
            addr_b_q     <= '0;
        end else begin
            clr_run_q    <= 1'b1;
            clear_done_q <= 1'b0;
            addr_b_q     <= ram_addr_b;

            s1_valid_q <= pix_acc;
            if (pix_acc) begin
                s1_bin_q <= pix_bin;
            end

            // A pending S1 write only exists while active; clear_start drops forwarding for the sweep.
            fwd_valid_q <= s1_valid_q && !clear_start;
            if (s1_valid_q) begin
                fwd_addr_q <= s1_bin_q;
                fwd_data_q <= s1_din;
            end

            rdp_valid_q <= rd_gnt;
            rdp_hit_q   <= rd_gnt && s1_valid_q && (s1_bin_q == rd_addr);
            rdp_data_q  <= s1_din;
            if (rdp_valid_q) begin
                rd_hold_q <= rd_now;
            end

            case (state_q)
                S_CLEAR: begin
                    if (clr_run_q) begin
                        if (clr_cnt_q == LAST_BIN) begin
                            state_q      <= S_ACTIVE;
                            clr_cnt_q    <= '0;
                            clear_done_q <= 1'b1;
                        end else begin
                            clr_cnt_q <= clr_cnt_q + ADDR_WIDTH'(1);
                        end
                    end
                end
                S_ACTIVE: begin
                    if (clear_start) begin
                        state_q   <= S_CLEAR;
                        clr_cnt_q <= '0;
                    end
                end
                default: state_q <= S_CLEAR;
            endcase
        end
    end

endmodule

// File: tb/tb_clahe_hist_rmw_ctrl.sv
// Scoreboard bench for clahe_hist_rmw_ctrl: a bin-count array model predicts every Port A
// accumulate write and every readout, and monitors compare them as the DUT presents them.
module tb_clahe_hist_rmw_ctrl;

    localparam int          DW   = 16;
    localparam int          AW   = 8;
    localparam int          NB   = 256;
    localparam int unsigned MAXC = (1 << DW) - 1;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clear_start = 1'b0;
    logic          clear_busy, clear_done;
    logic          pix_valid = 1'b0;
    logic [AW-1:0] pix_bin = '0;
    logic          pix_ready;
    logic          rd_req = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic          rd_gnt, rd_valid;
    logic [DW-1:0] rd_data;
    logic          ram_we_a;
    logic [AW-1:0] ram_addr_a, ram_addr_b;
    logic [DW-1:0] ram_din_a, ram_dout_b;

    logic [DW-1:0] mem [NB];

    int          n_checks = 0;
    int          n_errors = 0;
    int unsigned model [NB];
    logic        tb_active = 1'b0;
    logic [DW-1:0] rd_q [$];
    wr_t           wr_q [$];
    logic [DW-1:0] exp_rd;
    wr_t           exp_wr;

    always #5 clk = ~clk;

    clahe_hist_rmw_ctrl #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .DEPTH     (NB)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear_start(clear_start),
        .clear_busy (clear_busy),
        .clear_done (clear_done),
        .pix_valid  (pix_valid),
        .pix_bin    (pix_bin),
        .pix_ready  (pix_ready),
        .rd_req     (rd_req),
        .rd_addr    (rd_addr),
        .rd_gnt     (rd_gnt),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data),
        .ram_we_a   (ram_we_a),
        .ram_addr_a (ram_addr_a),
        .ram_din_a  (ram_din_a),
        .ram_addr_b (ram_addr_b),
        .ram_dout_b (ram_dout_b)
    );

    // Pseudo-dual-port RAM owned by the parent: registered read, old data on read-during-write.
    always @(posedge clk) begin
        if (ram_we_a) mem[ram_addr_a] <= ram_din_a;
        ram_dout_b <= mem[ram_addr_b];
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Readout monitor.
    always @(negedge clk) begin
        if (rd_valid === 1'b1) begin
            if (rd_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL rd_unexpected: rd_valid with data 0x%0h, no read outstanding", rd_data);
            end else begin
                exp_rd = rd_q.pop_front();
                chk("rd_data", 64'(rd_data), 64'(exp_rd));
            end
        end
    end

    // Accumulate-write monitor (clear writes are checked by the sweep task).
    always @(negedge clk) begin
        if (ram_we_a === 1'b1 && clear_busy === 1'b0) begin
            if (wr_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL wr_unexpected: write addr 0x%0h data 0x%0h not predicted", ram_addr_a, ram_din_a);
            end else begin
                exp_wr = wr_q.pop_front();
                chk("port_a_write", 64'({ram_addr_a, ram_din_a}), 64'(exp_wr));
            end
        end
    end

    task automatic step(input logic pv, input int pb, input logic rr, input int ra, input logic cs);
        @(posedge clk);
        #1;
        pix_valid   = pv;
        pix_bin     = AW'(pb);
        rd_req      = rr;
        rd_addr     = AW'(ra);
        clear_start = cs;
        @(negedge clk);
        chk("pix_ready", 64'(pix_ready), 64'(tb_active && !cs));
        chk("rd_gnt", 64'(rd_gnt), 64'(tb_active && rr && !pv && !cs));
        if (pv && pix_ready) begin
            if (model[pb] < MAXC) model[pb] = model[pb] + 1;
            wr_q.push_back('{a: AW'(pb), d: DW'(model[pb])});
        end
        if (rd_gnt) rd_q.push_back(DW'(model[ra]));
        if (cs) tb_active = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 0, 1'b0, 0, 1'b0);
    endtask

    // Starts on the negedge before sweep cycle 0; pokes ignored inputs partway through.
    task automatic check_sweep(input string tag);
        int bad = 0;
        int first_bad = -1;
        for (int k = 0; k < NB; k++) begin
            @(negedge clk);
            if (!(ram_we_a === 1'b1 && ram_addr_a === AW'(k) && ram_din_a === '0 &&
                  clear_busy === 1'b1 && pix_ready === 1'b0 && rd_gnt === 1'b0 &&
                  clear_done === 1'b0)) begin
                bad++;
                if (first_bad < 0) first_bad = k;
            end
            if (k == 40) begin
                pix_valid = 1'b1; pix_bin = 8'd5; rd_req = 1'b1; rd_addr = 8'd5; clear_start = 1'b1;
            end
            if (k == 41) clear_start = 1'b0;
            if (k == 60) begin
                pix_valid = 1'b0; rd_req = 1'b0;
            end
        end
        chk($sformatf("%s_sweep_bad_cycles(first=%0d)", tag, first_bad), 64'(bad), 64'd0);
        @(negedge clk);
        chk($sformatf("%s_done_busy_we", tag), 64'({clear_done, clear_busy, ram_we_a}), 64'(3'b100));
        for (int i = 0; i < NB; i++) model[i] = 0;
        tb_active = 1'b1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk(tag, 64'({clear_busy, clear_done, pix_ready, rd_gnt, rd_valid, rd_data,
                      ram_we_a, ram_addr_a, ram_din_a, ram_addr_b}), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit exceeded");
        $fatal(1, "watchdog");
    end

    initial begin
        pix_valid = 1'b1;
        rd_req    = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset_outputs");
        pix_valid = 1'b0;
        rd_req    = 1'b0;
        rst_n     = 1'b1;
        check_sweep("por");

        // Same-bin back-to-back pixels exercise forwarding.
        step(1'b1, 5, 1'b0, 0, 1'b0);
        step(1'b1, 5, 1'b0, 0, 1'b0);
        step(1'b1, 5, 1'b0, 0, 1'b0);
        step(1'b1, 7, 1'b0, 0, 1'b0);
        step(1'b0, 0, 1'b1, 5, 1'b0);
        step(1'b0, 0, 1'b1, 7, 1'b0);
        idle(2);

        // Alternating bins while readouts are requested: pixels must keep priority.
        for (int i = 0; i < 100; i++)
            step(1'b1, (i % 2) ? 10 : 9, 1'b1, int'($urandom_range(0, NB - 1)), 1'b0);
        step(1'b0, 0, 1'b1, 9, 1'b0);
        step(1'b0, 0, 1'b1, 10, 1'b0);
        idle(2);

        // Saturation of bin 3.
        repeat (65534) step(1'b1, 3, 1'b0, 0, 1'b0);
        repeat (3) step(1'b1, 3, 1'b0, 0, 1'b0);
        step(1'b0, 0, 1'b1, 3, 1'b0);
        idle(2);

        // Readout in the S1 write cycle of the same bin.
        step(1'b1, 4, 1'b0, 0, 1'b0);
        step(1'b0, 0, 1'b1, 4, 1'b0);
        idle(2);

        // Randomised mix over a small bin range to force collisions.
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 99) < 60, int'($urandom_range(0, 15)),
                 $urandom_range(0, 99) < 50, int'($urandom_range(0, 15)), 1'b0);
        for (int b = 0; b < 16; b++) step(1'b0, 0, 1'b1, b, 1'b0);
        idle(3);

        // clear_start with a pixel in S1; the pixel offered alongside must not be taken.
        step(1'b1, 12, 1'b0, 0, 1'b0);
        step(1'b1, 13, 1'b0, 0, 1'b1);
        check_sweep("clear_start");
        foreach (model[b]) if (b < 16) step(1'b0, 0, 1'b1, b, 1'b0);
        idle(3);

        // Reset mid-stream with a pixel in flight.
        step(1'b1, 20, 1'b0, 0, 1'b0);
        step(1'b1, 21, 1'b1, 0, 1'b0);
        @(posedge clk);
        #1;
        rst_n       = 1'b0;
        pix_valid   = 1'b0;
        rd_req      = 1'b0;
        clear_start = 1'b0;
        wr_q.delete();
        rd_q.delete();
        tb_active   = 1'b0;
        #1;
        check_reset_outputs("reset_midstream");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check_sweep("reset_restart");
        step(1'b0, 0, 1'b1, 3, 1'b0);
        step(1'b0, 0, 1'b1, 20, 1'b0);
        step(1'b0, 0, 1'b1, 21, 1'b0);
        idle(3);

        chk("rd_queue_drained", 64'(rd_q.size()), 64'd0);
        chk("wr_queue_drained", 64'(wr_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/clahe_hist_rmw_ctrl.md
Name: clahe_hist_rmw_ctrl

Overview:
- Read-modify-write sequencer that owns one pseudo-dual-port histogram RAM: Port A write-only, Port B read-only, 1-cycle registered read, read-during-write returns old data.
- Accumulates one histogram bin per pixel, clears the RAM by sweeping all addresses, and serves single-bin readout reads to the CDF stage.
- Sits between the tile pixel router and the RAM. The RAM is instantiated by the parent and driven only through this block's ram_* ports.

Parameters:
- DATA_WIDTH, 16, bin counter width (saturating).
- ADDR_WIDTH, 8, bin index width.
- DEPTH, 256, number of bins; must be at most 2^ADDR_WIDTH.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous, active-low reset.
- clear_start  in  1  pulse; requests a full-RAM clear.
- clear_busy  out  1  high while the clear sweep runs.
- clear_done  out  1  one-cycle pulse after the last clear write.
- pix_valid  in  1  pixel present.
- pix_bin  in  ADDR_WIDTH  bin index of the pixel.
- pix_ready  out  1  pixel accepted when pix_valid && pix_ready.
- rd_req  in  1  readout request.
- rd_addr  in  ADDR_WIDTH  readout bin.
- rd_gnt  out  1  readout accepted this cycle.
- rd_valid  out  1  readout data valid.
- rd_data  out  DATA_WIDTH  readout count.
- ram_we_a  out  1  RAM write enable.
- ram_addr_a  out  ADDR_WIDTH  RAM write address.
- ram_din_a  out  DATA_WIDTH  RAM write data.
- ram_addr_b  out  ADDR_WIDTH  RAM read address.
- ram_dout_b  in  DATA_WIDTH  RAM read data, valid 1 cycle after ram_addr_b.

Behaviour:
- Reset: all outputs 0. State enters S_CLEAR, so the post-reset auto-clear starts on the first clock after release. Clear counter = 0, forwarding register invalid.
- States: S_CLEAR, S_ACTIVE.
- S_CLEAR:
  - Cycle k (0..DEPTH-1): ram_we_a=1, ram_addr_a=k, ram_din_a=0.
  - clear_busy=1; pix_ready=0; rd_gnt=0.
  - After the write of k=DEPTH-1, go to S_ACTIVE and pulse clear_done in the first S_ACTIVE cycle.
  - clear_start during S_CLEAR is ignored (no restart).
- S_ACTIVE:
  - pix_ready=1 except in the cycle clear_start is sampled.
  - clear_start moves to S_CLEAR next cycle. A pixel already in stage 1 completes its write in the clear_start cycle. The forwarding register is invalidated on entry to S_CLEAR.
- Accumulate pipeline:
  - S0 (cycle t): on accept, ram_addr_b=pix_bin; capture s1_valid and s1_bin.
  - S1 (cycle t+1): old = fwd_hit ? fwd_data : ram_dout_b, where fwd_hit = fwd_valid && fwd_addr==s1_bin. Drive ram_we_a=1, ram_addr_a=s1_bin, ram_din_a=sat_inc(old).
  - sat_inc(x) = x+1, saturating at 2^DATA_WIDTH-1 (no wrap).
  - Throughput 1 pixel/cycle; back-to-back pixels to the same bin must each count.
- Forwarding register: on every S_ACTIVE write, capture fwd_addr/fwd_data; fwd_valid=1 for exactly the following cycle, else 0. Forwarding distance of 1 is sufficient because write latency is 1.
- Readout arbitration:
  - Pixels have strict priority for Port B.
  - rd_gnt = S_ACTIVE && rd_req && !pix_valid && !clear_start. rd_gnt is combinational, same cycle as rd_req.
  - On grant: ram_addr_b=rd_addr. Next cycle rd_valid=1 and rd_data = (write in the grant cycle to rd_addr) ? that write's data : ram_dout_b.
  - rd_valid is a one-cycle pulse; rd_data holds until the next rd_valid.
- Idle: ram_addr_b holds its last value; ram_we_a=0 whenever there is no S1 write and no clear write.
- Reset mid-operation: in-flight pixel and readout are discarded, then the auto-clear restarts from 0.

Decomposition:
- Shared package clahe_hist_pkg:
  - state enum (S_CLEAR, S_ACTIVE)
  - CNT_MAX = {DATA_WIDTH{1'b1}}
  - function sat_inc
- No sub-module; the RAM is instantiated by the parent. The forwarding compare stays inline.

Test Plan:
- Reset release: ram_we_a=1 for exactly 256 cycles with addresses 0..255 and data 0; clear_busy=1 throughout; clear_done one pulse in the cycle after addr 255; pix_ready=0 until then.
- Bins 5,5,5,7 on consecutive cycles, then read bin 5 and bin 7 → rd_data=3 and 1. Write data observed on Port A for bin 5 is 1,2,3 (forwarding exercised).
- Alternating bins 9,10,9,10 (×50 each), then read → both 50; rd_gnt=0 in every cycle with pix_valid=1.
- Preload bin 3 with 0xFFFE via 65534 pixels, then 3 more pixels to bin 3 → readout 0xFFFF, no wrap.
- rd_req for bin 4 in the cycle after a pixel to bin 4 (its S1 write cycle) → rd_valid next cycle with the incremented value.
- clear_start mid-stream with a pixel in S1 → that write completes, then a 256-cycle clear; all bins read 0 after clear_done. Repeat with rst_n asserted mid-stream → outputs 0 immediately, auto-clear restarts from address 0.
